// File: rtl/rv32_pkg.sv
// Shared RV32 encoding constants: ALU operation codes, major opcodes and funct fields.
// The decode block uses the same constants, so both sides stay in step.
package rv32_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: decoded request -> 32-bit RV32 R/I-type word plus illegal flag.
// I-type table mirrors the core decoder as-is (010 -> ORI, 011 -> ANDI, 110 -> SLLI).
module instr_field_pack
  import rv32_pkg::*;
(
  input  logic [2:0]  alu_control,
  input  logic        alu_src,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [11:0] imm,
  output logic [31:0] instr,
  output logic        illegal
);

  logic [11:0] upper;
  logic [2:0]  funct3;
  logic [6:0]  opcode;

  always_comb begin
    upper   = '0;
    funct3  = F3_ADD_SUB;
    opcode  = OP_RTYPE;
    illegal = 1'b0;
    if (!alu_src) begin
      upper = {F7_BASE, rs2};
      case (alu_control)
        ALU_ADD: funct3 = F3_ADD_SUB;
        ALU_SUB: begin
          funct3 = F3_ADD_SUB;
          upper  = {F7_ALT, rs2};
        end
        ALU_SLL: funct3 = F3_SLL;
        ALU_SLT: funct3 = F3_SLT;
        ALU_XOR: funct3 = F3_XOR;
        ALU_SRL: funct3 = F3_SR;
        ALU_OR:  funct3 = F3_OR;
        default: funct3 = F3_AND;
      endcase
    end else begin
      opcode = OP_ITYPE;
      upper  = imm;
      case (alu_control)
        3'b000: funct3 = F3_ADD_SUB;
        3'b010: funct3 = F3_OR;
        3'b011: funct3 = F3_AND;
        3'b110, 3'b111: begin
          // Shift amount lives in imm[4:0]; any high bit set is not encodable.
          funct3  = (alu_control == 3'b110) ? F3_SLL : F3_SR;
          upper   = {7'b0000000, imm[4:0]};
          illegal = |imm[11:5];
        end
        default: illegal = 1'b1;
      endcase
    end
    instr = {upper, rs1, funct3, rd, opcode};
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32 encoder: packs requests into words, tags them with an incrementing
// byte address and buffers them in a 2-entry FIFO; illegal requests are dropped and counted.
module instr_encoder
  import rv32_pkg::*;
#(
  parameter int unsigned          ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_alu_control,
  input  logic              in_alu_src,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [11:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_illegal,
  output logic [7:0]        illegal_cnt
);

  logic [31:0]       pack_instr;
  logic              pack_illegal;

  logic [31:0]       instr_reg [2];
  logic [ADDR_W-1:0] addr_reg  [2];
  logic [1:0]        count_reg;
  logic [ADDR_W-1:0] next_addr_reg;
  logic              err_reg;
  logic [7:0]        cnt_reg;

  logic accept;
  logic push;
  logic drop;
  logic pop;

  instr_field_pack u_pack (
    .alu_control (in_alu_control),
    .alu_src     (in_alu_src),
    .rd          (in_rd),
    .rs1         (in_rs1),
    .rs2         (in_rs2),
    .imm         (in_imm),
    .instr       (pack_instr),
    .illegal     (pack_illegal)
  );

  assign in_ready    = (count_reg != 2'd2);
  assign out_valid   = (count_reg != 2'd0);
  assign out_instr   = instr_reg[0];
  assign out_addr    = addr_reg[0];
  assign err_illegal = err_reg;
  assign illegal_cnt = cnt_reg;

  assign accept = in_valid && in_ready;
  assign push   = accept && !pack_illegal;
  assign drop   = accept && pack_illegal;
  assign pop    = out_valid && out_ready;

  // Slot 0 is always the head; slot 1 only fills when the head is stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg     <= 2'd0;
      next_addr_reg <= BASE_ADDR;
      instr_reg[0]  <= '0;
      instr_reg[1]  <= '0;
      addr_reg[0]   <= BASE_ADDR;
      addr_reg[1]   <= BASE_ADDR;
      err_reg       <= 1'b0;
      cnt_reg       <= 8'd0;
    end else if (flush) begin
      count_reg     <= 2'd0;
      next_addr_reg <= BASE_ADDR;
      err_reg       <= 1'b0;
      cnt_reg       <= 8'd0;
    end else begin
      if (push) begin
        next_addr_reg <= next_addr_reg + ADDR_W'(4);
      end
      if (drop) begin
        err_reg <= 1'b1;
        if (cnt_reg != 8'hFF) begin
          cnt_reg <= cnt_reg + 8'd1;
        end
      end
      case (count_reg)
        2'd0: begin
          if (push) begin
            instr_reg[0] <= pack_instr;
            addr_reg[0]  <= next_addr_reg;
            count_reg    <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            instr_reg[0] <= pack_instr;
            addr_reg[0]  <= next_addr_reg;
          end else if (push) begin
            instr_reg[1] <= pack_instr;
            addr_reg[1]  <= next_addr_reg;
            count_reg    <= 2'd2;
          end else if (pop) begin
            count_reg    <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            instr_reg[0] <= instr_reg[1];
            addr_reg[0]  <= addr_reg[1];
            count_reg    <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-encoded words, back-pressure, illegal drops,
// flush and mid-stream reset.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_alu_control;
  logic        in_alu_src;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [11:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err_illegal;
  logic [7:0]  illegal_cnt;

  int n_vec = 0;
  int n_bad = 0;

  instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_alu_control (in_alu_control),
    .in_alu_src     (in_alu_src),
    .in_rd          (in_rd),
    .in_rs1         (in_rs1),
    .in_rs2         (in_rs2),
    .in_imm         (in_imm),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_addr       (out_addr),
    .err_illegal    (err_illegal),
    .illegal_cnt    (illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %-18s got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %-18s 0x%08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] ctrl, input logic src, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
    in_valid       = 1'b1;
    in_alu_control = ctrl;
    in_alu_src     = src;
    in_rd          = rd;
    in_rs1         = rs1;
    in_rs2         = rs2;
    in_imm         = imm;
  endtask

  task automatic send(input logic [2:0] ctrl, input logic src, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
    set_req(ctrl, src, rd, rs1, rs2, imm);
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_alu_control = '0; in_alu_src = 1'b0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    step();
    step();
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_instr", out_instr, 32'h0);
    check("rst out_addr", out_addr, 32'h0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst err", 32'(err_illegal), 32'd0);
    check("rst cnt", 32'(illegal_cnt), 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Basic encodings, streaming with out_ready high
    send(3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 12'h0);
    check("add valid", 32'(out_valid), 32'd1);
    check("add instr", out_instr, 32'h002081B3);
    check("add addr", out_addr, 32'h0);
    do_flush();
    send(3'b001, 1'b0, 5'd5, 5'd6, 5'd7, 12'h0);
    check("sub instr", out_instr, 32'h407302B3);
    check("sub addr", out_addr, 32'h0);
    send(3'b000, 1'b1, 5'd1, 5'd0, 5'd0, 12'h005);
    check("addi instr", out_instr, 32'h00500093);
    check("addi addr", out_addr, 32'h4);
    send(3'b010, 1'b1, 5'd2, 5'd1, 5'd0, 12'h0F0);
    check("ori instr", out_instr, 32'h0F00E113);
    check("ori addr", out_addr, 32'h8);
    send(3'b110, 1'b1, 5'd4, 5'd4, 5'd0, 12'h003);
    check("slli instr", out_instr, 32'h00321213);
    check("slli addr", out_addr, 32'hC);
    step();
    check("drained valid", 32'(out_valid), 32'd0);

    // Back-pressure: three requests against a stalled sink
    do_flush();
    out_ready = 1'b0;
    set_req(3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 12'h0);
    step();
    check("bp1 in_ready", 32'(in_ready), 32'd1);
    set_req(3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 12'h0);
    step();
    check("bp2 in_ready", 32'(in_ready), 32'd0);
    check("bp2 head", out_instr, 32'h000000B3);
    set_req(3'b000, 1'b0, 5'd3, 5'd0, 5'd0, 12'h0);
    step();
    check("bp3 in_ready", 32'(in_ready), 32'd0);
    check("bp3 hold instr", out_instr, 32'h000000B3);
    check("bp3 hold addr", out_addr, 32'h0);
    out_ready = 1'b1;
    step();
    check("bp pop1 instr", out_instr, 32'h00000133);
    check("bp pop1 addr", out_addr, 32'h4);
    step();
    check("bp pop2 instr", out_instr, 32'h000001B3);
    check("bp pop2 addr", out_addr, 32'h8);
    in_valid = 1'b0;
    step();
    check("bp empty", 32'(out_valid), 32'd0);

    // Illegal requests are dropped without consuming an address
    do_flush();
    send(3'b101, 1'b1, 5'd1, 5'd1, 5'd0, 12'h001);
    check("ill1 valid", 32'(out_valid), 32'd0);
    check("ill1 err", 32'(err_illegal), 32'd1);
    check("ill1 cnt", 32'(illegal_cnt), 32'd1);
    send(3'b110, 1'b1, 5'd1, 5'd1, 5'd0, 12'h020);
    check("ill2 valid", 32'(out_valid), 32'd0);
    check("ill2 cnt", 32'(illegal_cnt), 32'd2);
    send(3'b000, 1'b1, 5'd1, 5'd0, 5'd0, 12'h005);
    check("post-ill instr", out_instr, 32'h00500093);
    check("post-ill addr", out_addr, 32'h0);
    send(3'b010, 1'b0, 5'd7, 5'd8, 5'd9, 12'h0);
    check("and instr", out_instr, 32'h009473B3);
    check("and addr", out_addr, 32'h4);
    send(3'b111, 1'b1, 5'd1, 5'd2, 5'd0, 12'h01F);
    check("srli instr", out_instr, 32'h01F15093);
    check("srli addr", out_addr, 32'h8);
    check("srli err kept", 32'(err_illegal), 32'd1);
    step();

    // Flush with two buffered words and the error flag set
    out_ready = 1'b0;
    send(3'b100, 1'b1, 5'd1, 5'd1, 5'd0, 12'h0);
    send(3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 12'h0);
    send(3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 12'h0);
    check("pre-flush full", 32'(in_ready), 32'd0);
    check("pre-flush cnt", 32'(illegal_cnt), 32'd3);
    do_flush();
    check("flush valid", 32'(out_valid), 32'd0);
    check("flush err", 32'(err_illegal), 32'd0);
    check("flush cnt", 32'(illegal_cnt), 32'd0);
    check("flush in_ready", 32'(in_ready), 32'd1);
    set_req(3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 12'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush vs accept", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    send(3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 12'h0);
    check("post-flush addr", out_addr, 32'h0);
    check("post-flush instr", out_instr, 32'h002081B3);
    step();

    // Counter saturation
    for (int i = 0; i < 260; i++) begin
      send(3'b001, 1'b1, 5'd0, 5'd0, 5'd0, 12'h0);
    end
    check("cnt saturate", 32'(illegal_cnt), 32'd255);

    // Reset mid-stream
    out_ready = 1'b0;
    send(3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 12'h0);
    send(3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 12'h0);
    rst_n = 1'b0;
    step();
    check("mid-rst valid", 32'(out_valid), 32'd0);
    check("mid-rst instr", out_instr, 32'h0);
    check("mid-rst addr", out_addr, 32'h0);
    check("mid-rst in_ready", 32'(in_ready), 32'd1);
    check("mid-rst err", 32'(err_illegal), 32'd0);
    check("mid-rst cnt", 32'(illegal_cnt), 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(3'b110, 1'b0, 5'd1, 5'd0, 5'd0, 12'h0);
    check("post-rst addr", out_addr, 32'h0);
    check("post-rst xor", out_instr, 32'h000040B3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Streaming RV32 instruction encoder, the inverse of the core's opcode/funct decode path. Accepts decoded operation requests (alu_control, alu_src, register indices, immediate) and emits 32-bit R-type (0110011) or I-type (0010011) words with an incrementing word address. It feeds the instruction-memory loader and the test harness. Round-trip requirement: decoding any emitted word must return the request's exact alu_control and alu_src.

Parameters:
ADDR_W, 32, width of out_addr.
BASE_ADDR, 0, first address after reset or flush; must be 4-byte aligned.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset, synchronous, active-low.
flush  in  1  synchronous clear of buffer, address and error state.
in_valid  in  1  request valid.
in_ready  out  1  encoder can accept a request.
in_alu_control  in  3  ALU operation code, core encoding.
in_alu_src  in  1  0 = register operand (R-type), 1 = immediate (I-type).
in_rd  in  5  destination register.
in_rs1  in  5  source register 1.
in_rs2  in  5  source register 2; ignored when alu_src = 1.
in_imm  in  12  immediate; ignored when alu_src = 0.
out_valid  out  1  encoded word valid.
out_ready  in  1  sink accepts the word.
out_instr  out  32  encoded instruction.
out_addr  out  ADDR_W  byte address of out_instr.
err_illegal  out  1  sticky flag: an illegal request was dropped.
illegal_cnt  out  8  number of dropped requests, saturating at 255.

Behaviour:
- Reset (rst_n = 0 at a clk edge): out_valid = 0, out_instr = 0, out_addr = BASE_ADDR, err_illegal = 0, illegal_cnt = 0, buffer empty, next address = BASE_ADDR. in_ready = 1 after reset.
- Accept: a request is accepted on a clk edge where in_valid = 1 and in_ready = 1.
- in_ready = buffer not full. It is a function of occupancy only; there is no combinational path from out_ready or in_valid.
- Buffer: 2-entry FIFO holding {instr, addr}. The head drives out_instr and out_addr.
- Latency: a word accepted at edge N is visible at the head at N+1 if the buffer was empty.
- out_valid = buffer not empty. The head is popped on an edge where out_valid = 1 and out_ready = 1.
- Simultaneous push and pop with 1 entry: occupancy stays 1 and ordering is preserved.
- A full buffer cannot push (in_ready = 0).
- out_instr and out_addr hold stable while out_valid = 1 and out_ready = 0.
- Address: each legal push takes the current next address, then next address += 4. Wraps modulo 2^ADDR_W. Illegal requests do not consume an address.
- R-type (alu_src = 0): opcode 0110011, funct7 = 0000000 except as noted. alu_control to funct3:
  000 -> 000
  001 -> 000 with funct7 = 0100000
  100 -> 001
  101 -> 010
  110 -> 100
  111 -> 101
  011 -> 110
  010 -> 111
  All 8 codes are legal.
- I-type (alu_src = 1): opcode 0010011, instr[31:20] = imm. alu_control to funct3:
  000 -> 000
  010 -> 110
  011 -> 111
  110 -> 001
  111 -> 101
- Shifts (alu_control 110 or 111 with alu_src = 1): instr[31:25] = 0 and instr[24:20] = imm[4:0]. imm[11:5] must be 0, otherwise the request is illegal.
- Illegal requests: alu_src = 1 with alu_control 001, 100 or 101, or a shift with imm[11:5] != 0.
  - The request is accepted (handshake completes) and dropped, nothing is pushed.
  - err_illegal is set and illegal_cnt increments; both update on the accept edge + 1.
- Field packing: instr = {funct7 or imm, rs2, rs1, funct3, rd, opcode}, standard RV32 bit positions.
- flush = 1: at the edge, the buffer empties, next address = BASE_ADDR, err_illegal = 0, illegal_cnt = 0.
  - Flush overrides a same-cycle accept or pop; the accepted request is discarded.
  - in_ready = 1 on the following cycle.
- Reset has priority over flush. Reset mid-stream discards all buffered words.

Decomposition:
- Shared package rv32_pkg holds:
  - ALU code constants: ALU_ADD 000, ALU_SUB 001, ALU_AND 010, ALU_OR 011, ALU_SLL 100, ALU_SLT 101, ALU_XOR 110, ALU_SRL 111.
  - OP_RTYPE 0110011 and OP_ITYPE 0010011.
  - Funct3 constants.
  - These constants are shared with the decode block.
- The encoder uses the core's R-type and I-type mappings exactly, including I-type 010 -> ORI, 011 -> ANDI, 110 -> SLLI. Entries are not normalised.
- Sub-module instr_field_pack: combinational {alu_control, alu_src, regs, imm} -> {instr, illegal}.
- The FIFO, address counter and error state stay in the top module.

Test Plan:
- Reset, then ADD (000, src 0, rd 3, rs1 1, rs2 2) with out_ready = 1 -> next cycle out_instr = 0x002081B3, out_addr = 0x0.
- SUB (001, src 0, rd 5, rs1 6, rs2 7) followed by ADDI (000, src 1, rd 1, rs1 0, imm 5) -> 0x407302B3 at 0x0, then 0x00500093 at 0x4.
- ORI code 010 (src 1, rd 2, rs1 1, imm 0x0F0) -> 0x0F00E113. SLLI code 110 (rd 4, rs1 4, imm 3) -> 0x00321213.
- out_ready = 0 with 3 back-to-back requests -> in_ready drops after 2 accepts and the head holds stable. Release out_ready -> words emitted in order with addresses 0x0, 0x4, 0x8.
- Illegal requests: code 101 with src 1 -> dropped, err_illegal = 1, illegal_cnt = 1, no address consumed. Shift with imm = 0x020 -> dropped, illegal_cnt = 2. Next legal word gets the unconsumed address.
- Flush with 2 buffered words and err set -> out_valid = 0, flags cleared, next word at BASE_ADDR. Hold rst_n = 0 mid-stream -> all outputs at their reset values.
